reg_dump_scanner: RTL and testbench

//   Hardware counterpart of the bench-side register inspector. Drives the

---
 rtl/reg_dump_scanner.sv | 143 ++++++++++++++
 tb/tb_reg_dump_scanner.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner
//   Sweeps the sccomp register file through its debug port and streams every
//   captured word out over a valid/ready interface (UART or display consumer).
//   For each index the scanner drives reg_sel, waits SEL_LAT cycles for the
//   register file to settle, captures reg_data, and then holds the word until
//   the consumer accepts it. After that it moves on to the next index.
//
// Parameters
//   NUM_REGS   number of registers swept, indices 0..NUM_REGS-1 (2..32)
//   SEL_LAT    cycles from a reg_sel change to the reg_data capture edge (1..7)
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   start      one-cycle request to begin a sweep (ignored while busy)
//   abort      synchronous cancel of a sweep in progress
//   reg_sel    register index driven to the sccomp debug port
//   reg_data   register contents returned by sccomp
//   out_valid  out_data/out_idx hold a captured register
//   out_ready  consumer accepts the word when high together with out_valid
//   out_data   captured register value
//   out_idx    index of out_data
//   busy       high from start acceptance until the sweep ends
//   done       one-cycle pulse when the final word has been accepted
module reg_dump_scanner #(
    parameter int NUM_REGS = 32,
    parameter int SEL_LAT  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        busy,
    output logic        done
);

    // Termination compares against the last index. With NUM_REGS=32 this is
    // 31, so the 5-bit index never has to wrap to end the sweep.
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
    // lat_cnt starts at 0 on the edge reg_sel changes, so the capture happens
    // on the edge where it has reached SEL_LAT-1.
    localparam logic [2:0] LAT_LAST = 3'(SEL_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [2:0]  lat_cnt_reg;
    logic [31:0] out_data_reg;
    logic [4:0]  out_idx_reg;
    logic        out_valid_reg;
    logic        busy_reg;
    logic        done_reg;

    // reg_sel is the sweep index itself. It changes only when a sweep starts
    // or on a handshake, and it keeps its value after an abort.
    assign reg_sel   = idx_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            lat_cnt_reg   <= '0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // done is a single-cycle pulse
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // abort takes priority over a simultaneous start
                    if (start && !abort) begin
                        state_reg   <= ST_WAIT;
                        idx_reg     <= '0;
                        lat_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else if (lat_cnt_reg == LAT_LAST) begin
                        out_data_reg  <= reg_data;
                        out_idx_reg   <= idx_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_OUT;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 3'd1;
                    end
                end

                ST_OUT: begin
                    // abort also wins over the final handshake, so no done
                    if (abort) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            idx_reg     <= idx_reg + 5'd1;
                            lat_cnt_reg <= '0;
                            state_reg   <= ST_WAIT;
                        end
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
`timescale 1ns/1ps
module tb_reg_dump_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rstn;
    logic tb_start, tb_abort, tb_ready;
    int   which;   // 0: SEL_LAT=1 instance, 1: SEL_LAT=3 instance

    logic [31:0] rf [32];

    // SEL_LAT=1 instance
    logic        s0_start, s0_abort, s0_ready, s0_valid, s0_busy, s0_done;
    logic [4:0]  s0_sel, s0_idx;
    logic [31:0] s0_rdata, s0_data;
    // SEL_LAT=3 instance
    logic        s1_start, s1_abort, s1_ready, s1_valid, s1_busy, s1_done;
    logic [4:0]  s1_sel, s1_idx;
    logic [31:0] s1_rdata, s1_data;

    assign s0_start = (which == 0) ? tb_start : 1'b0;
    assign s0_abort = (which == 0) ? tb_abort : 1'b0;
    assign s0_ready = (which == 0) ? tb_ready : 1'b0;
    assign s1_start = (which == 1) ? tb_start : 1'b0;
    assign s1_abort = (which == 1) ? tb_abort : 1'b0;
    assign s1_ready = (which == 1) ? tb_ready : 1'b0;

    // Register file with no latency for the SEL_LAT=1 instance
    assign s0_rdata = rf[s0_sel];

    // Register file whose output settles two edges after reg_sel changes.
    // A capture earlier than the third edge picks up the previous register.
    logic [4:0] s1_sel_d1 = '0;
    logic [4:0] s1_sel_d2 = '0;
    always @(posedge clk) begin
        s1_sel_d1 <= s1_sel;
        s1_sel_d2 <= s1_sel_d1;
    end
    assign s1_rdata = rf[s1_sel_d2];

    reg_dump_scanner #(.NUM_REGS(32), .SEL_LAT(1)) dut0 (
        .clk(clk), .rstn(rstn), .start(s0_start), .abort(s0_abort),
        .reg_sel(s0_sel), .reg_data(s0_rdata), .out_valid(s0_valid),
        .out_ready(s0_ready), .out_data(s0_data), .out_idx(s0_idx),
        .busy(s0_busy), .done(s0_done)
    );

    reg_dump_scanner #(.NUM_REGS(32), .SEL_LAT(3)) dut1 (
        .clk(clk), .rstn(rstn), .start(s1_start), .abort(s1_abort),
        .reg_sel(s1_sel), .reg_data(s1_rdata), .out_valid(s1_valid),
        .out_ready(s1_ready), .out_data(s1_data), .out_idx(s1_idx),
        .busy(s1_busy), .done(s1_done)
    );

    // Outputs of the selected instance
    logic        v_valid, v_busy, v_done;
    logic [4:0]  v_sel, v_idx;
    logic [31:0] v_data;
    assign v_valid = (which == 1) ? s1_valid : s0_valid;
    assign v_busy  = (which == 1) ? s1_busy  : s0_busy;
    assign v_done  = (which == 1) ? s1_done  : s0_done;
    assign v_sel   = (which == 1) ? s1_sel   : s0_sel;
    assign v_idx   = (which == 1) ? s1_idx   : s0_idx;
    assign v_data  = (which == 1) ? s1_data  : s0_data;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    word_t sb[$];     // expected words in order
    int    hs_q[$];   // negedge cycle of each accepted word

    int n_tests = 0;
    int n_fail  = 0;

    // Pulses start, consumes words against the scoreboard, and stops a few
    // cycles after done. A word at hold_idx is back-pressured for hold_len
    // cycles. A second start is pulsed while restart_idx is pending.
    task automatic run_sweep(input int hold_idx, input int hold_len, input int restart_idx,
                             output int k, output int words, output int dones,
                             output int done_cyc);
        int    held;
        bit    restarted;
        int    tail;
        word_t exp;
        held = 0; restarted = 0; tail = -1;
        words = 0; dones = 0; done_cyc = -1;
        sb.delete();
        hs_q.delete();
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            exp.idx  = 5'(i);
            exp.data = rf[i];
            sb.push_back(exp);
        end
        tb_start = 1'b1;
        tb_ready = 1'b1;
        k = cyc + 1;
        for (int c = 0; c < 400 && tail != 0; c++) begin
            @(negedge clk);
            tb_start = 1'b0;
            if (tail > 0) tail--;
            if (v_valid && int'(v_idx) == hold_idx && held < hold_len) begin
                tb_ready = 1'b0;
                held++;
                n_tests++;
                if (sb.size() == 0 || v_idx !== sb[0].idx || v_data !== sb[0].data ||
                    v_sel !== sb[0].idx) begin
                    n_fail++;
                    $display("FAIL hold_stable: idx=%0d data=%08h sel=%0d, required idx=%0d sel=%0d data=%08h",
                             v_idx, v_data, v_sel, hold_idx, hold_idx, rf[hold_idx]);
                end
            end else begin
                tb_ready = 1'b1;
                if (v_valid) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_word: idx=%0d data=%08h, required no word", v_idx, v_data);
                    end else begin
                        exp = sb.pop_front();
                        if (v_idx !== exp.idx || v_data !== exp.data || v_sel !== exp.idx) begin
                            n_fail++;
                            $display("FAIL word: idx=%0d data=%08h sel=%0d, required idx=%0d data=%08h sel=%0d",
                                     v_idx, v_data, v_sel, exp.idx, exp.data, exp.idx);
                        end
                    end
                    words++;
                    hs_q.push_back(cyc);
                    $display("[TB] word idx=%0d data=%08h cyc=%0d", v_idx, v_data, cyc - k);
                end
            end
            if (restart_idx >= 0 && !restarted && v_valid && int'(v_idx) == restart_idx) begin
                tb_start  = 1'b1;
                restarted = 1'b1;
            end
            if (v_done) begin
                dones++;
                done_cyc = cyc;
                $display("[TB] done at +%0d cycles", cyc - k);
                if (tail < 0) tail = 6;
            end
        end
        tb_start = 1'b0;
        tb_ready = 1'b1;
        n_tests++;
        if (tail != 0) begin
            n_fail++;
            $display("FAIL sweep_timeout: no done within budget, words=%0d, required done", words);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; tb_start = 1'b0; tb_abort = 1'b0; tb_ready = 1'b1; which = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s0_valid, s0_busy, s0_done, s0_sel, s0_idx, s0_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0: valid=%b busy=%b done=%b sel=%0d idx=%0d data=%08h, required all 0",
                     s0_valid, s0_busy, s0_done, s0_sel, s0_idx, s0_data);
        end
        n_tests++;
        if ({s1_valid, s1_busy, s1_done, s1_sel, s1_idx, s1_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: valid=%b busy=%b done=%b sel=%0d idx=%0d data=%08h, required all 0",
                     s1_valid, s1_busy, s1_done, s1_sel, s1_idx, s1_data);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (s0_valid !== 1'b0 || s0_busy !== 1'b0 || s1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy0=%b busy1=%b, required 0 0 0",
                     s0_valid, s0_busy, s1_busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic check_sweep(input string name, input int words, input int dones,
                               input int done_cyc, input int k, input int want_done);
        n_tests++;
        if (words != 32 || dones != 1) begin
            n_fail++;
            $display("FAIL %s_count: words=%0d dones=%0d, required 32 and 1", name, words, dones);
        end
        n_tests++;
        if (done_cyc - k != want_done) begin
            n_fail++;
            $display("FAIL %s_done_time: +%0d, required +%0d", name, done_cyc - k, want_done);
        end
        n_tests++;
        if (v_busy !== 1'b0 || v_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_after: busy=%b valid=%b, required 0 0", name, v_busy, v_valid);
        end
    endtask

    task automatic test_full_sweep();
        int k, words, dones, done_cyc, bad;
        which = 0;
        run_sweep(-1, 0, -1, k, words, dones, done_cyc);
        check_sweep("full", words, dones, done_cyc, k, 64);
        bad = 0;
        foreach (hs_q[i]) if (hs_q[i] != k + 1 + 2 * i) bad++;
        n_tests++;
        if (bad != 0 || hs_q.size() != 32) begin
            n_fail++;
            $display("FAIL full_word_timing: %0d off-schedule of %0d, required 0 of 32", bad, hs_q.size());
        end
    endtask

    task automatic test_backpressure();
        int k, words, dones, done_cyc;
        which = 0;
        run_sweep(3, 5, -1, k, words, dones, done_cyc);
        check_sweep("bp", words, dones, done_cyc, k, 69);
        n_tests++;
        if (hs_q.size() < 5 || hs_q[3] != k + 12 || hs_q[4] != k + 14) begin
            n_fail++;
            $display("FAIL bp_timing: idx3 at +%0d idx4 at +%0d, required +12 and +14",
                     (hs_q.size() > 3) ? hs_q[3] - k : -1, (hs_q.size() > 4) ? hs_q[4] - k : -1);
        end
    endtask

    task automatic test_sel_lat3();
        int k, words, dones, done_cyc, bad;
        which = 1;
        run_sweep(-1, 0, -1, k, words, dones, done_cyc);
        check_sweep("lat3", words, dones, done_cyc, k, 128);
        bad = 0;
        foreach (hs_q[i]) if (hs_q[i] != k + 3 + 4 * i) bad++;
        n_tests++;
        if (bad != 0 || hs_q.size() != 32) begin
            n_fail++;
            $display("FAIL lat3_word_timing: %0d off-schedule of %0d, required 0 of 32", bad, hs_q.size());
        end
        which = 0;
    endtask

    task automatic test_abort();
        int    k, words, dones, done_cyc, stray;
        bit    aborted;
        word_t exp;
        which = 0; aborted = 0; words = 0;
        sb.delete();
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            exp.idx  = 5'(i);
            exp.data = rf[i];
            sb.push_back(exp);
        end
        tb_start = 1'b1; tb_ready = 1'b1;
        for (int c = 0; c < 200 && !aborted; c++) begin
            @(negedge clk);
            tb_start = 1'b0;
            if (v_valid && v_idx == 5'd10) begin
                n_tests++;
                if (v_data !== sb[0].data || sb[0].idx !== 5'd10) begin
                    n_fail++;
                    $display("FAIL abort_pending: data=%08h, required idx 10 data=%08h", v_data, rf[10]);
                end
                tb_abort = 1'b1; tb_ready = 1'b0; aborted = 1;
                $display("[TB] abort with idx=10 pending");
            end else if (v_valid) begin
                exp = sb.pop_front();
                n_tests++;
                if (v_idx !== exp.idx || v_data !== exp.data) begin
                    n_fail++;
                    $display("FAIL abort_word: idx=%0d data=%08h, required idx=%0d data=%08h",
                             v_idx, v_data, exp.idx, exp.data);
                end
                words++;
                $display("[TB] word idx=%0d data=%08h", v_idx, v_data);
            end
        end
        n_tests++;
        if (!aborted) begin
            n_fail++;
            $display("FAIL abort_timeout: idx 10 never pending, required it within budget");
        end
        @(negedge clk);
        tb_abort = 1'b0; tb_ready = 1'b1;
        n_tests++;
        if (v_valid !== 1'b0 || v_busy !== 1'b0 || v_done !== 1'b0 || v_sel !== 5'd10 || words != 10) begin
            n_fail++;
            $display("FAIL abort_effect: valid=%b busy=%b done=%b sel=%0d words=%0d, required 0 0 0 10 10",
                     v_valid, v_busy, v_done, v_sel, words);
        end
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (v_valid || v_busy || v_done) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d active cycles after abort, required 0", stray);
        end
        run_sweep(-1, 0, -1, k, words, dones, done_cyc);
        check_sweep("restart", words, dones, done_cyc, k, 64);
    endtask

    task automatic test_back_to_back_start();
        int k, words, dones, done_cyc;
        which = 0;
        run_sweep(-1, 0, 5, k, words, dones, done_cyc);
        check_sweep("start_ignored", words, dones, done_cyc, k, 64);
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        int stray;
        which = 0; found = 0;
        @(negedge clk);
        tb_start = 1'b1; tb_ready = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            tb_start = 1'b0;
            if (!v_valid && v_busy && v_sel == 5'd7) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_timeout: WAIT on idx 7 not reached, required within budget");
        end
        rstn = 1'b0;
        #1;
        $display("[TB] rstn asserted in WAIT on idx 7");
        n_tests++;
        if ({v_valid, v_busy, v_done, v_sel, v_idx, v_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: valid=%b busy=%b done=%b sel=%0d idx=%0d data=%08h, required all 0",
                     v_valid, v_busy, v_done, v_sel, v_idx, v_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (v_valid || v_busy || v_done) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: %0d active cycles after reset, required 0", stray);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_sel_lat3();
        test_abort();
        test_back_to_back_start();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
